// File: rtl/cache_bus_mem_responder.sv
// Burst memory responder for the cache bus: word memory with read/write bursts,
// configurable read latency and write-response latency, sticky protocol error.
// Ports: clk, rst (sync, active-high); ce_i enables ren_i/wen_i requests;
//   read:  raddr_i, rlen_i, rready_i -> rdata_o, rvalid_o
//   write: waddr_i, wlen_i, wdata_i, wvalid_i, wlast_i -> bvalid_o
//   status: busy_o (not idle), err_o (sticky wlast/length disagreement)
module cache_bus_mem_responder #(
  parameter int MEM_WORDS = 4096,
  parameter int RD_LAT    = 2,
  parameter int B_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        ren_i,
  input  logic [31:0] raddr_i,
  input  logic [3:0]  rlen_i,
  input  logic        rready_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  input  logic        wen_i,
  input  logic [31:0] waddr_i,
  input  logic [3:0]  wlen_i,
  input  logic [31:0] wdata_i,
  input  logic        wvalid_i,
  input  logic        wlast_i,
  output logic        bvalid_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE, R_WAIT, R_DATA, W_DATA, W_RESP, DONE
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    beat_q, beat_d;
  logic [3:0]    lat_q, lat_d;
  logic          err_q, err_d;

  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] idx;
  logic          last_beat;
  logic          we;

  logic unused_addr;
  assign unused_addr = ^{raddr_i[31:AW+2], raddr_i[1:0],
                         waddr_i[31:AW+2], waddr_i[1:0]};

  // Word index wraps naturally at the top of memory.
  assign idx       = addr_q + AW'(beat_q);
  assign last_beat = (beat_q == len_q);
  assign we        = (state_q == W_DATA) && wvalid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

  // Memory is never cleared; a reset edge suppresses the write in flight.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem[idx] <= wdata_i;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (ce_i && wen_i) begin
          state_d = W_DATA;
          addr_d  = waddr_i[AW+1:2];
          len_d   = wlen_i;
          beat_d  = '0;
          lat_d   = '0;
        end else if (ce_i && ren_i) begin
          state_d = R_WAIT;
          addr_d  = raddr_i[AW+1:2];
          len_d   = rlen_i;
          beat_d  = '0;
          lat_d   = '0;
        end
      end
      R_WAIT: begin
        if (lat_q == 4'(RD_LAT - 1)) begin
          state_d = R_DATA;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      R_DATA: begin
        if (rready_i) begin
          if (last_beat) state_d = DONE;
          else           beat_d  = beat_q + 4'd1;
        end
      end
      W_DATA: begin
        if (wvalid_i) begin
          // wlast must coincide exactly with the final counted beat.
          if (wlast_i != last_beat) err_d = 1'b1;
          if (wlast_i || last_beat) begin
            state_d = W_RESP;
            lat_d   = '0;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      W_RESP: begin
        if (lat_q == 4'(B_LAT - 1)) begin
          state_d = DONE;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rvalid_o = (state_q == R_DATA);
    rdata_o  = rvalid_o ? mem[idx] : 32'd0;
    bvalid_o = (state_q == W_RESP) && (lat_q == 4'(B_LAT - 1));
    busy_o   = (state_q != IDLE);
    err_o    = err_q;
  end

endmodule

// File: tb/tb_cache_bus_mem_responder.sv
// Self-checking bench for cache_bus_mem_responder.
// Read data is checked against a scoreboard queue fed from a memory model.
module tb_cache_bus_mem_responder;

  localparam int MW = 256;
  localparam int RL = 2;
  localparam int BL = 1;

  logic        clk, rst, ce, ren, rready, wen, wvalid, wlast;
  logic [31:0] raddr, waddr, wdata, rdata;
  logic [3:0]  rlen, wlen;
  logic        rvalid, bvalid, busy, err;

  cache_bus_mem_responder #(
    .MEM_WORDS(MW), .RD_LAT(RL), .B_LAT(BL)
  ) dut (
    .clk(clk), .rst(rst), .ce_i(ce),
    .ren_i(ren), .raddr_i(raddr), .rlen_i(rlen),
    .rready_i(rready), .rdata_o(rdata), .rvalid_o(rvalid),
    .wen_i(wen), .waddr_i(waddr), .wlen_i(wlen),
    .wdata_i(wdata), .wvalid_i(wvalid), .wlast_i(wlast),
    .bvalid_o(bvalid), .busy_o(busy), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mdl [MW];
  logic [31:0] exp_q [$];

  task automatic test_reset();
    rst = 1'b1; ce = 0; ren = 0; wen = 0; rready = 0;
    wvalid = 0; wlast = 0; raddr = 0; waddr = 0;
    wdata = 0; rlen = 0; wlen = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_err++; $display("FAIL rst_rvalid got %b want 0", rvalid);
    end
    n_cmp++;
    if (rdata !== 32'd0) begin
      n_err++; $display("FAIL rst_rdata got %h want 0", rdata);
    end
    n_cmp++;
    if (bvalid !== 1'b0) begin
      n_err++; $display("FAIL rst_bvalid got %b want 0", bvalid);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL rst_busy got %b want 0", busy);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++; $display("FAIL rst_err got %b want 0", err);
    end
    rst = 1'b0;
  endtask

  task automatic test_write(input string nm, input logic [31:0] addr,
                            input logic [3:0] len, input logic [31:0] base,
                            input int wlast_at, input int gap_at,
                            input logic also_ren, input logic exp_err);
    int b, cyc;
    logic done_w, gapped;
    @(negedge clk);
    ce = 1; wen = 1; ren = also_ren;
    waddr = addr; raddr = addr; wlen = len; rlen = len;
    wvalid = 0; wlast = 0;
    b = 0; cyc = 0; done_w = 0; gapped = 0;
    while (!done_w && cyc < 40) begin
      @(negedge clk);
      cyc++;
      ce = 0; wen = 0; ren = 0;
      n_cmp++;
      if (bvalid !== 1'b0) begin
        n_err++; $display("FAIL %s bvalid_early got %b want 0", nm, bvalid);
      end
      if (b == gap_at && !gapped) begin
        wvalid = 0; wlast = 0; gapped = 1;
      end else begin
        wvalid = 1;
        wdata = base + 32'(b);
        wlast = (b == wlast_at);
        mdl[int'(((addr >> 2) + 32'(b)) % MW)] = wdata;
        done_w = (b == int'(len)) || (b == wlast_at);
        b++;
      end
    end
    if (!done_w) begin
      n_err++; $display("FAIL %s timeout beats %0d want done", nm, b);
    end
    @(negedge clk);
    wvalid = 0; wlast = 0;
    n_cmp++;
    if (bvalid !== 1'b1) begin
      n_err++; $display("FAIL %s bvalid got %b want 1", nm, bvalid);
    end
    @(negedge clk);
    n_cmp++;
    if (bvalid !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s done bvalid %b busy %b want 0 1", nm, bvalid, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL %s idle busy got %b want 0", nm, busy);
    end
    n_cmp++;
    if (err !== exp_err) begin
      n_err++; $display("FAIL %s err got %b want %b", nm, err, exp_err);
    end
  endtask

  task automatic test_read(input string nm, input logic [31:0] addr,
                           input logic [3:0] len, input int stall_beat,
                           input int stall_n);
    int cyc, beat, stalls;
    logic first;
    @(negedge clk);
    ce = 1; ren = 1; raddr = addr; rlen = len; rready = 0;
    for (int i = 0; i <= int'(len); i++)
      exp_q.push_back(mdl[int'(((addr >> 2) + 32'(i)) % MW)]);
    cyc = 0; beat = 0; stalls = stall_n; first = 1;
    while (exp_q.size() > 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      ce = 0; ren = 0; rready = 0;
      if (rvalid) begin
        if (first) begin
          n_cmp++;
          if (cyc != RL + 1) begin
            n_err++;
            $display("FAIL %s first_beat cycle %0d want %0d", nm, cyc, RL + 1);
          end
          first = 0;
        end
        n_cmp++;
        if (rdata !== exp_q[0]) begin
          n_err++;
          $display("FAIL %s beat%0d rdata %h want %h", nm, beat, rdata, exp_q[0]);
        end
        if (beat == stall_beat && stalls > 0) begin
          stalls--;
        end else begin
          rready = 1;
          void'(exp_q.pop_front());
          beat++;
        end
      end
    end
    if (exp_q.size() > 0) begin
      n_err++; $display("FAIL %s timeout beats %0d want %0d", nm, beat, len + 1);
    end
    exp_q.delete();
    n_cmp++;
    if (beat != int'(len) + 1) begin
      n_err++; $display("FAIL %s beats %0d want %0d", nm, beat, len + 1);
    end
    @(negedge clk);
    rready = 0;
    n_cmp++;
    if (busy !== 1'b1 || rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL %s done busy %b rvalid %b want 1 0", nm, busy, rvalid);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL %s idle busy got %b want 0", nm, busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clk);
    ce = 1; ren = 1; raddr = 32'((MW - 1) * 4); rlen = 1; rready = 0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      ce = 0; ren = 0;
    end while (!rvalid && cyc < 20);
    n_cmp++;
    if (cyc != RL + 1) begin
      n_err++; $display("FAIL mid_first cycle %0d want %0d", cyc, RL + 1);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_cmp++;
    if (rvalid !== 1'b0 || busy !== 1'b0 || rdata !== 32'd0) begin
      n_err++;
      $display("FAIL mid_rst rvalid %b busy %b rdata %h want 0 0 0",
               rvalid, busy, rdata);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_err got %b want 0", err);
    end
  endtask

  initial begin
    test_reset();
    test_write("wr4", 32'h100, 4'd3, 32'hA0, 3, -1, 1'b0, 1'b0);
    test_read("rd4", 32'h100, 4'd3, -1, 0);
    test_read("rd_stall", 32'h100, 4'd3, 1, 2);
    test_write("both", 32'h200, 4'd0, 32'h55, 0, -1, 1'b1, 1'b0);
    test_read("rd_both", 32'h200, 4'd0, -1, 0);
    test_write("gap", 32'h180, 4'd2, 32'hC0, 2, 1, 1'b0, 1'b0);
    test_read("rd_gap", 32'h180, 4'd2, -1, 0);
    test_write("early_last", 32'h140, 4'd3, 32'hB0, 1, -1, 1'b0, 1'b1);
    test_read("rd_early", 32'h140, 4'd1, -1, 0);
    test_write("wrap_wr", 32'((MW - 1) * 4), 4'd1, 32'hD0, 1, -1, 1'b0, 1'b1);
    test_read("wrap_rd", 32'((MW - 1) * 4), 4'd1, -1, 0);
    test_reset_mid();
    test_read("persist", 32'h100, 4'd3, -1, 0);
    test_write("no_last", 32'h300, 4'd1, 32'hE0, -1, -1, 1'b0, 1'b1);
    test_read("rd_no_last", 32'h300, 4'd1, -1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
